trdb_resync_checker: RTL and testbench
======================================

Name: trdb_resync_checker

Overview:
Receive-side counterpart of the encoder's resync counter. It sits in the trace sink/decoder front end, after packet framing.
- Watches decoded packet headers and tracks sync lock.
- Counts cycles or non-sync packets since the last sync packet.
- Flags when the encoder has failed to resynchronise within MAX_VALUE + SLACK.
- Lets the decoder discard packets received while unsynchronised and report sync-interval violations.

Parameters:
- MODE, default CYCLE_MODE: count unit; CYCLE_MODE counts enabled cycles, PACKET_MODE counts accepted non-sync packets.
- MAX_VALUE, default 16'hFFFF: resync interval the encoder is configured with; must match the encoder-side setting.
- SLACK, default 2: extra units tolerated beyond MAX_VALUE before declaring late; 0 is legal.
- LATE_CNT_W, default 8: width of the saturating late-event counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- enable_i  in  1  checker/trace-sink enabled
- packet_valid_i  in  1  one decoded packet header presented this cycle
- packet_format_i  in  2  packet format field
- packet_subformat_i  in  2  packet subformat field (meaningful only for format 3)
- clear_err_i  in  1  clears late_count_o
- synced_o  out  1  state == SYNCED
- resync_due_o  out  1  SYNCED and counter_o >= MAX_VALUE (sync expected now)
- resync_late_o  out  1  one-cycle pulse on entry to OVERDUE
- dropped_o  out  1  one-cycle pulse: non-sync packet received while UNSYNC
- late_count_o  out  LATE_CNT_W  saturating count of late events
- counter_o  out  CW  current count; CW = $clog2(MAX_VALUE+SLACK+1)

Behaviour:
- Reset values:
  - state UNSYNC; counter 0.
  - synced_o = 0, resync_due_o = 0, resync_late_o = 0, dropped_o = 0.
  - late_count_o = 0, counter_o = 0.
- Sync packet definition: packet_valid_i && format == F_SYNC (2'b11) && subformat in {SF_START (2'b00), SF_TRAP (2'b01)}. Format 3 subformat 3 (support) is non-sync.
- All inputs are sampled on the rising clock edge. State, counter and pulse outputs are registered, so responses are visible in the cycle after the triggering edge.
- UNSYNC state:
  - counter held at 0.
  - sync packet -> SYNCED, counter 0.
  - non-sync packet with enable_i -> dropped_o pulse, stay UNSYNC.
- SYNCED state:
  - sync packet -> counter 0.
  - otherwise, if enable_i, increment the counter:
    - CYCLE_MODE: every cycle.
    - PACKET_MODE: only on cycles with packet_valid_i.
  - If the incremented value == MAX_VALUE+SLACK -> OVERDUE, resync_late_o pulse, late_count +1 (saturates at all-ones).
- OVERDUE state:
  - counter holds at MAX_VALUE+SLACK; no further late pulses.
  - sync packet -> SYNCED, counter 0.
  - Packets are not dropped in OVERDUE.
- enable_i low in any state:
  - next state UNSYNC, counter 0.
  - no drop pulses, no late pulses.
  - enable_i takes priority over a simultaneous sync packet.
- Simultaneous events:
  - sync packet on the same edge the threshold would be reached -> sync wins; no late pulse.
  - clear_err_i together with a late event -> late_count becomes 1.
  - clear_err_i alone -> late_count becomes 0.
- Counter never wraps; the maximum reachable value is MAX_VALUE+SLACK.
- Reset asserted mid-operation -> immediately returns all state to reset values; the first packet afterwards must be a sync packet.

Decomposition:
- trdb_pkg holds:
  - trdb_resync_state_e {UNSYNC, SYNCED, OVERDUE};
  - F_SYNC, SF_START, SF_TRAP, SF_SUPPORT constants;
  - existing CYCLE_MODE/PACKET_MODE.
- No sub-module. The saturating late counter stays inline in this block.

Test Plan:
- MAX_VALUE=8, SLACK=2, CYCLE_MODE; enable_i=1; sync at edge E0, no further sync -> synced_o=1 after E0; counter_o=8 after E8 with resync_due_o=1; counter_o=10 after E10, state OVERDUE, resync_late_o=1 for exactly one cycle, late_count_o=1.
- Same configuration, sync at E9 -> counter_o=0 after E9, no late pulse, synced_o stays 1.
- PACKET_MODE, MAX_VALUE=4, SLACK=0; sync, then 4 non-sync packets separated by idle cycles -> counter_o steps 1,2,3,4 only on packet cycles; late pulse on the 4th packet.
- From reset, send format 0 packet, then format 3 subformat 3, then format 3 subformat 0 -> dropped_o pulses twice; synced_o=1 after the third packet.
- OVERDUE, then deassert enable_i for 1 cycle with a sync packet present -> state UNSYNC, counter_o=0; reassert and send sync -> SYNCED.
- LATE_CNT_W=2; force 4 late events -> late_count_o saturates at 3; clear_err_i coincident with the 5th event -> late_count_o=1.

Source files
------------

// File: rtl/trdb_pkg.sv
// ----------------------------------------------------------------------------
// trdb_pkg
// Shared definitions for the trace decoder front end: count-unit modes,
// packet header format/subformat codes and the resync checker state type.
// ----------------------------------------------------------------------------
package trdb_pkg;

    // Count unit used by resync counters on both encoder and decoder sides.
    localparam int unsigned CYCLE_MODE  = 0;
    localparam int unsigned PACKET_MODE = 1;

    // Packet header codes.
    localparam logic [1:0] F_SYNC     = 2'b11;
    localparam logic [1:0] SF_START   = 2'b00;
    localparam logic [1:0] SF_TRAP    = 2'b01;
    localparam logic [1:0] SF_SUPPORT = 2'b11;

    typedef enum logic [1:0] {
        UNSYNC  = 2'd0,
        SYNCED  = 2'd1,
        OVERDUE = 2'd2
    } trdb_resync_state_e;

    // Only start and trap packets carry a full address/context and re-establish
    // decoder lock; the support subformat shares format 3 but does not.
    function automatic logic is_sync_pkt(input logic       valid,
                                         input logic [1:0] fmt,
                                         input logic [1:0] subfmt);
        return valid && (fmt == F_SYNC) &&
               ((subfmt == SF_START) || (subfmt == SF_TRAP));
    endfunction

endpackage

// File: rtl/trdb_resync_checker.sv
// ----------------------------------------------------------------------------
// trdb_resync_checker
// Receive-side resync interval checker. Tracks decoder sync lock from decoded
// packet headers, counts cycles (CYCLE_MODE) or non-sync packets (PACKET_MODE)
// since the last sync packet, and flags when the encoder has not resynced
// within MAX_VALUE + SLACK units.
//
// Ports:
//   clk_i              clock
//   rst_ni             asynchronous active-low reset
//   enable_i           checker / trace sink enabled
//   packet_valid_i     a decoded packet header is presented this cycle
//   packet_format_i    packet format field
//   packet_subformat_i packet subformat field (format 3 only)
//   clear_err_i        clears late_count_o
//   synced_o           decoder is locked (state SYNCED)
//   resync_due_o       locked and counter has reached MAX_VALUE
//   resync_late_o      one-cycle pulse on entry to OVERDUE
//   dropped_o          one-cycle pulse: non-sync packet seen while unlocked
//   late_count_o       saturating count of late events
//   counter_o          current count since last sync
// ----------------------------------------------------------------------------
module trdb_resync_checker
    import trdb_pkg::*;
#(
    parameter int unsigned MODE       = CYCLE_MODE,
    parameter int unsigned MAX_VALUE  = 16'hFFFF,
    parameter int unsigned SLACK      = 2,
    parameter int unsigned LATE_CNT_W = 8,
    localparam int unsigned CW = ((MAX_VALUE + SLACK) > 0) ?
                                 $clog2(MAX_VALUE + SLACK + 1) : 1
)(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  enable_i,
    input  logic                  packet_valid_i,
    input  logic [1:0]            packet_format_i,
    input  logic [1:0]            packet_subformat_i,
    input  logic                  clear_err_i,
    output logic                  synced_o,
    output logic                  resync_due_o,
    output logic                  resync_late_o,
    output logic                  dropped_o,
    output logic [LATE_CNT_W-1:0] late_count_o,
    output logic [CW-1:0]         counter_o
);

    localparam logic [CW-1:0] LIMIT = CW'(MAX_VALUE + SLACK);
    localparam logic [CW-1:0] DUE   = CW'(MAX_VALUE);

    trdb_resync_state_e    r_state;
    trdb_resync_state_e    w_state_nxt;
    logic [CW-1:0]         r_count;
    logic [CW-1:0]         w_count_nxt;
    logic [CW-1:0]         w_count_inc;
    logic                  r_late;
    logic                  w_late_nxt;
    logic                  r_drop;
    logic                  w_drop_nxt;
    logic [LATE_CNT_W-1:0] r_late_cnt;
    logic                  w_sync;
    logic                  w_count_step;

    assign w_sync       = is_sync_pkt(packet_valid_i, packet_format_i,
                                      packet_subformat_i);
    assign w_count_step = (MODE == PACKET_MODE) ? packet_valid_i : 1'b1;
    // Only used while SYNCED, where r_count < LIMIT, so this cannot wrap.
    assign w_count_inc  = r_count + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_late_nxt  = 1'b0;
        w_drop_nxt  = 1'b0;
        // A disabled sink loses lock unconditionally, even if a sync packet
        // arrives on the same cycle.
        if (!enable_i) begin
            w_state_nxt = UNSYNC;
            w_count_nxt = '0;
        end else begin
            case (r_state)
                UNSYNC: begin
                    w_count_nxt = '0;
                    if (w_sync) begin
                        w_state_nxt = SYNCED;
                    end else if (packet_valid_i) begin
                        w_drop_nxt = 1'b1;
                    end
                end
                SYNCED: begin
                    // Sync takes precedence over reaching the threshold.
                    if (w_sync) begin
                        w_count_nxt = '0;
                    end else if (w_count_step) begin
                        w_count_nxt = w_count_inc;
                        if (w_count_inc == LIMIT) begin
                            w_state_nxt = OVERDUE;
                            w_late_nxt  = 1'b1;
                        end
                    end
                end
                OVERDUE: begin
                    if (w_sync) begin
                        w_state_nxt = SYNCED;
                        w_count_nxt = '0;
                    end else begin
                        w_count_nxt = LIMIT;
                    end
                end
                default: begin
                    w_state_nxt = UNSYNC;
                    w_count_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= UNSYNC;
            r_count <= '0;
            r_late  <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_late  <= w_late_nxt;
            r_drop  <= w_drop_nxt;
        end
    end

    // Clear and a new late event on the same edge leave exactly that event.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_late_cnt <= '0;
        end else if (clear_err_i) begin
            r_late_cnt <= LATE_CNT_W'(w_late_nxt);
        end else if (w_late_nxt && (r_late_cnt != '1)) begin
            r_late_cnt <= r_late_cnt + 1'b1;
        end
    end

    assign synced_o      = (r_state == SYNCED);
    assign resync_due_o  = (r_state == SYNCED) && (r_count >= DUE);
    assign resync_late_o = r_late;
    assign dropped_o     = r_drop;
    assign late_count_o  = r_late_cnt;
    assign counter_o     = r_count;

endmodule

// File: tb/tb_trdb_resync_checker.sv
// ----------------------------------------------------------------------------
// tb_trdb_resync_checker
// Directed bench for trdb_resync_checker. Three instances share the stimulus:
//   u_cyc : CYCLE_MODE,  MAX_VALUE=8, SLACK=2, LATE_CNT_W=8
//   u_pkt : PACKET_MODE, MAX_VALUE=4, SLACK=0, LATE_CNT_W=8
//   u_sat : CYCLE_MODE,  MAX_VALUE=2, SLACK=0, LATE_CNT_W=2
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// ----------------------------------------------------------------------------
module tb_trdb_resync_checker;
    import trdb_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       vld;
    logic [1:0] fmt;
    logic [1:0] sub;
    logic       clr;

    logic       c_synced, c_due, c_late, c_drop;
    logic [7:0] c_lcnt;
    logic [3:0] c_cnt;

    logic       p_synced, p_due, p_late, p_drop;
    logic [7:0] p_lcnt;
    logic [2:0] p_cnt;

    logic       s_synced, s_due, s_late, s_drop;
    logic [1:0] s_lcnt;
    logic [1:0] s_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    trdb_resync_checker #(.MODE(CYCLE_MODE), .MAX_VALUE(8), .SLACK(2),
                          .LATE_CNT_W(8)) u_cyc (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .packet_valid_i(vld),
        .packet_format_i(fmt), .packet_subformat_i(sub), .clear_err_i(clr),
        .synced_o(c_synced), .resync_due_o(c_due), .resync_late_o(c_late),
        .dropped_o(c_drop), .late_count_o(c_lcnt), .counter_o(c_cnt));

    trdb_resync_checker #(.MODE(PACKET_MODE), .MAX_VALUE(4), .SLACK(0),
                          .LATE_CNT_W(8)) u_pkt (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .packet_valid_i(vld),
        .packet_format_i(fmt), .packet_subformat_i(sub), .clear_err_i(clr),
        .synced_o(p_synced), .resync_due_o(p_due), .resync_late_o(p_late),
        .dropped_o(p_drop), .late_count_o(p_lcnt), .counter_o(p_cnt));

    trdb_resync_checker #(.MODE(CYCLE_MODE), .MAX_VALUE(2), .SLACK(0),
                          .LATE_CNT_W(2)) u_sat (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .packet_valid_i(vld),
        .packet_format_i(fmt), .packet_subformat_i(sub), .clear_err_i(clr),
        .synced_o(s_synced), .resync_due_o(s_due), .resync_late_o(s_late),
        .dropped_o(s_drop), .late_count_o(s_lcnt), .counter_o(s_cnt));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pkt(input logic v, input logic [1:0] f, input logic [1:0] s);
        vld = v;
        fmt = f;
        sub = s;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        clr   = 1'b0;
        pkt(1'b0, 2'd0, 2'd0);
        tick();
        tick();

        // Reset state
        chk("rst_synced",  32'(c_synced), 32'd0);
        chk("rst_due",     32'(c_due),    32'd0);
        chk("rst_late",    32'(c_late),   32'd0);
        chk("rst_drop",    32'(c_drop),   32'd0);
        chk("rst_lcnt",    32'(c_lcnt),   32'd0);
        chk("rst_cnt",     32'(c_cnt),    32'd0);

        rst_n = 1'b1;
        tick();

        // Cycle mode: sync at E0, then let it run to OVERDUE
        pkt(1'b1, F_SYNC, SF_START);
        tick();
        chk("t1_synced_E0", 32'(c_synced), 32'd1);
        chk("t1_cnt_E0",    32'(c_cnt),    32'd0);
        pkt(1'b0, 2'd0, 2'd0);
        repeat (7) tick();
        chk("t1_cnt_E7",    32'(c_cnt),    32'd7);
        chk("t1_due_E7",    32'(c_due),    32'd0);
        tick();
        chk("t1_cnt_E8",    32'(c_cnt),    32'd8);
        chk("t1_due_E8",    32'(c_due),    32'd1);
        tick();
        chk("t1_cnt_E9",    32'(c_cnt),    32'd9);
        chk("t1_late_E9",   32'(c_late),   32'd0);
        tick();
        chk("t1_cnt_E10",   32'(c_cnt),    32'd10);
        chk("t1_late_E10",  32'(c_late),   32'd1);
        chk("t1_lcnt_E10",  32'(c_lcnt),   32'd1);
        chk("t1_synced_E10", 32'(c_synced), 32'd0);
        chk("t1_due_E10",   32'(c_due),    32'd0);
        tick();
        chk("t1_late_E11",  32'(c_late),   32'd0);
        chk("t1_cnt_E11",   32'(c_cnt),    32'd10);
        chk("t1_lcnt_E11",  32'(c_lcnt),   32'd1);

        // Resync from OVERDUE, then sync at E9 (before threshold)
        pkt(1'b1, F_SYNC, SF_START);
        tick();
        chk("t2_synced_E0", 32'(c_synced), 32'd1);
        chk("t2_cnt_E0",    32'(c_cnt),    32'd0);
        pkt(1'b0, 2'd0, 2'd0);
        repeat (8) tick();
        chk("t2_cnt_E8",    32'(c_cnt),    32'd8);
        pkt(1'b1, F_SYNC, SF_START);
        tick();
        chk("t2_cnt_E9",    32'(c_cnt),    32'd0);
        chk("t2_late_E9",   32'(c_late),   32'd0);
        chk("t2_synced_E9", 32'(c_synced), 32'd1);
        pkt(1'b0, 2'd0, 2'd0);
        repeat (9) tick();
        chk("t2_cnt_9",     32'(c_cnt),    32'd9);
        // Sync on the very edge that would reach MAX_VALUE+SLACK
        pkt(1'b1, F_SYNC, SF_START);
        tick();
        chk("t2_thr_cnt",   32'(c_cnt),    32'd0);
        chk("t2_thr_late",  32'(c_late),   32'd0);
        chk("t2_thr_lcnt",  32'(c_lcnt),   32'd1);
        pkt(1'b0, 2'd0, 2'd0);
        tick();
        chk("t2_cnt_1",     32'(c_cnt),    32'd1);

        // Asynchronous reset mid-operation, between clock edges
        rst_n = 1'b0;
        #2;
        chk("arst_cnt",     32'(c_cnt),    32'd0);
        chk("arst_synced",  32'(c_synced), 32'd0);
        chk("arst_lcnt",    32'(c_lcnt),   32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Packet mode: counts only on packet cycles, late on 4th packet
        pkt(1'b1, F_SYNC, SF_START);
        tick();
        chk("t3_synced",    32'(p_synced), 32'd1);
        chk("t3_cnt0",      32'(p_cnt),    32'd0);
        for (int k = 1; k <= 4; k++) begin
            pkt(1'b0, 2'd0, 2'd0);
            tick();
            chk("t3_idle_cnt", 32'(p_cnt), 32'(k - 1));
            pkt(1'b1, 2'd0, 2'd0);
            tick();
            chk("t3_pkt_cnt",  32'(p_cnt),  32'(k));
            chk("t3_pkt_late", 32'(p_late), (k == 4) ? 32'd1 : 32'd0);
        end
        pkt(1'b0, 2'd0, 2'd0);
        tick();
        chk("t3_late_off",  32'(p_late),   32'd0);
        chk("t3_cnt_hold",  32'(p_cnt),    32'd4);
        chk("t3_lcnt",      32'(p_lcnt),   32'd1);
        chk("t3_synced_0",  32'(p_synced), 32'd0);

        // Drops while UNSYNC
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        pkt(1'b1, 2'd0, 2'd0);
        tick();
        chk("t4_drop1",     32'(c_drop),   32'd1);
        chk("t4_synced1",   32'(c_synced), 32'd0);
        pkt(1'b0, 2'd0, 2'd0);
        tick();
        chk("t4_drop_gap",  32'(c_drop),   32'd0);
        pkt(1'b1, F_SYNC, SF_SUPPORT);
        tick();
        chk("t4_drop2",     32'(c_drop),   32'd1);
        chk("t4_synced2",   32'(c_synced), 32'd0);
        pkt(1'b1, F_SYNC, SF_START);
        tick();
        chk("t4_drop3",     32'(c_drop),   32'd0);
        chk("t4_synced3",   32'(c_synced), 32'd1);

        // OVERDUE, then enable low with a sync present
        pkt(1'b0, 2'd0, 2'd0);
        repeat (10) tick();
        chk("t5_cnt_ovd",   32'(c_cnt),    32'd10);
        en = 1'b0;
        pkt(1'b1, F_SYNC, SF_START);
        tick();
        chk("t5_dis_synced", 32'(c_synced), 32'd0);
        chk("t5_dis_cnt",   32'(c_cnt),    32'd0);
        chk("t5_dis_late",  32'(c_late),   32'd0);
        pkt(1'b1, 2'd0, 2'd0);
        tick();
        chk("t5_dis_drop",  32'(c_drop),   32'd0);
        en = 1'b1;
        pkt(1'b1, 2'd2, 2'd0);
        tick();
        chk("t5_uns_drop",  32'(c_drop),   32'd1);
        pkt(1'b1, F_SYNC, SF_TRAP);
        tick();
        chk("t5_trap_synced", 32'(c_synced), 32'd1);
        chk("t5_trap_cnt",  32'(c_cnt),    32'd0);
        chk("t5_trap_drop", 32'(c_drop),   32'd0);

        // Late-counter saturation (2-bit) and clear interaction
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            pkt(1'b1, F_SYNC, SF_START);
            tick();
            pkt(1'b0, 2'd0, 2'd0);
            tick();
            tick();
            chk("t6_late",  32'(s_late), 32'd1);
            chk("t6_lcnt",  32'(s_lcnt), (i < 3) ? 32'(i) : 32'd3);
        end
        pkt(1'b1, F_SYNC, SF_START);
        tick();
        pkt(1'b0, 2'd0, 2'd0);
        tick();
        clr = 1'b1;
        tick();
        chk("t6_clr_ev_lcnt", 32'(s_lcnt), 32'd1);
        chk("t6_clr_ev_late", 32'(s_late), 32'd1);
        tick();
        chk("t6_clr_lcnt",  32'(s_lcnt),   32'd0);
        chk("t6_ovd_cnt",   32'(s_cnt),    32'd2);
        clr = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
